// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS frequency-sweep controller.
//   state_e       : sweep controller FSM states
//   PHASE_W_DEF   : default phase/frequency word width
//   DWELL_W_DEF   : default dwell counter width
package dds_ctrl_pkg;

  localparam int unsigned PHASE_W_DEF = 16;
  localparam int unsigned DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dds_sweep_ctrl_phase_acc.sv
// Registered modulo-2^W phase accumulator.
//   clk, rst : clock, async active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : add inc_i this cycle
//   inc_i    : phase increment
//   acc_o    : accumulated phase (registered)
module phase_acc #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] inc_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;

  // Carry out of the MSB is dropped: the phase wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + inc_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding accumulated phase words to a DDS over
// an AXI-stream style handshake.
//   clk, rst             : clock, async active-high reset
//   start, abort         : single-cycle launch / cancel requests
//   f_start/f_stop/f_step: sweep increments, sampled at accepted start
//   dwell                : accepted beats per frequency (0 behaves as 1)
//   m_axis_phase_*       : phase beat stream to the DDS
//   busy                 : sweep in progress (RUN or DONE)
//   done                 : one-cycle pulse on natural completion
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic               m_axis_phase_tvalid,
  output logic [PHASE_W-1:0] m_axis_phase_tdata,
  input  logic               m_axis_phase_tready,
  output logic               busy,
  output logic               done
);

  state_e             state_q;
  logic [PHASE_W-1:0] inc_q;
  logic [PHASE_W-1:0] stop_q;
  logic [PHASE_W-1:0] step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               tvalid_q;
  logic               busy_q;
  logic               done_q;

  logic               start_ok;
  logic               hs;
  logic               last_beat;
  logic [PHASE_W:0]   next_inc;
  logic               acc_en;

  assign start_ok  = (state_q == IDLE) && start && !abort;
  assign hs        = (state_q == RUN) && tvalid_q && m_axis_phase_tready;
  assign last_beat = (cnt_q == (dwell_q - DWELL_W'(1)));
  // One extra bit so increment + step cannot wrap below f_stop.
  assign next_inc  = {1'b0, inc_q} + {1'b0, step_q};
  // A beat accepted in the abort cycle is abandoned with the sweep.
  assign acc_en    = hs && !abort;

  phase_acc #(.W(PHASE_W)) u_phase_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_ok),
    .en_i  (acc_en),
    .inc_i (inc_q),
    .acc_o (m_axis_phase_tdata)
  );

  // Sweep FSM with registered stream/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      inc_q    <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          if (start_ok) begin
            inc_q    <= f_start;
            stop_q   <= f_stop;
            step_q   <= f_step;
            dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
            cnt_q    <= '0;
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (hs) begin
            if (last_beat) begin
              cnt_q <= '0;
              if (next_inc <= {1'b0, stop_q}) begin
                inc_q <= next_inc[PHASE_W-1:0];
              end else begin
                tvalid_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + DWELL_W'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_phase_tvalid = tvalid_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus randomized
// sweeps compared against a beat-list model built from the sweep rules.
module tb_dds_sweep_ctrl;

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] f_start = '0;
  logic [PW-1:0] f_stop = '0;
  logic [PW-1:0] f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic          tvalid;
  logic [PW-1:0] tdata;
  logic          tready = 1'b0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  int unsigned exp_q[$];
  int unsigned got_q[$];

  dds_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .f_start             (f_start),
    .f_stop              (f_stop),
    .f_step              (f_step),
    .dwell               (dwell),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tdata  (tdata),
    .m_axis_phase_tready (tready),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected phase words: each frequency held for 'dwell' beats, phase is the
  // running sum of increments of all previous beats, modulo 2^16.
  task automatic build_model(input int unsigned fs, input int unsigned fe,
                             input int unsigned st, input int unsigned dw,
                             input int max_beats);
    int unsigned inc = fs;
    int unsigned ph  = 0;
    int unsigned d   = (dw == 0) ? 1 : dw;
    exp_q.delete();
    forever begin
      for (int unsigned k = 0; k < d; k++) begin
        if (exp_q.size() >= max_beats) return;
        exp_q.push_back(ph);
        ph = (ph + inc) % 65536;
      end
      if (inc + st <= fe) inc = inc + st;
      else return;
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return 1'(($urandom % 4) != 0);
    endcase
  endfunction

  // Launch a sweep and monitor it. With abort_after>0, abort is issued once
  // that many beats have been accepted; otherwise the sweep must end naturally.
  task automatic run_sweep(input string name, input int unsigned fs, input int unsigned fe,
                           input int unsigned st, input int unsigned dw,
                           input int mode, input int abort_after);
    int  cyc = 0;
    int  ndone = 0;
    int  run_cycles = 0;
    bit  fin = 0;
    bit  held = 0;
    logic [PW-1:0] held_val = '0;
    build_model(fs, fe, st, dw, (abort_after > 0) ? abort_after : 100000);
    got_q.delete();
    @(posedge clk); #1;
    f_start = PW'(fs); f_stop = PW'(fe); f_step = PW'(st); dwell = DW'(dw);
    start = 1'b1; tready = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    f_start = PW'($urandom); f_stop = PW'($urandom); f_step = PW'($urandom);
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held) chk({name, "_stable"}, tvalid ? tdata : held_val, held_val);
      held     = tvalid && !tready;
      held_val = tdata;
      if (busy && !done) run_cycles++;
      if (tvalid && tready) got_q.push_back(tdata);
      if (done) begin
        ndone++;
        chk({name, "_busy_in_done"}, busy, 1);
        chk({name, "_tvalid_in_done"}, tvalid, 0);
      end else if (ndone > 0) begin
        fin = 1;
      end
      if (abort_after > 0 && got_q.size() >= abort_after) fin = 1;
      @(posedge clk); #1;
      tready = ready_for(mode, cyc);
      if (cyc == 1) begin
        start = 1'b1;  // ignored mid-sweep, must not relatch
        f_start = 16'h1234;
      end else begin
        start = 1'b0;
      end
    end
    chk({name, "_no_timeout"}, fin, 1);
    if (abort_after > 0) begin
      abort = 1'b1; tready = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk({name, "_abort_tvalid"}, tvalid, 0);
      chk({name, "_abort_busy"}, busy, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk({name, "_abort_no_done"}, ndone, 0);
    end else begin
      chk({name, "_done_count"}, ndone, 1);
      chk({name, "_busy_after"}, busy, 0);
      if (mode == 0) chk({name, "_no_bubbles"}, run_cycles, exp_q.size());
    end
    chk({name, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #22 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    run_sweep("basic", 16'h0100, 16'h0300, 16'h0100, 2, 0, 0);
    chk("basic_model_len", exp_q.size(), 6);
    chk("basic_last", exp_q[5], 16'h0900);
    run_sweep("toggle", 16'h0100, 16'h0300, 16'h0100, 2, 1, 0);
    run_sweep("wrap_abort", 16'h8000, 16'hFFFF, 16'h0000, 1, 0, 5);
    run_sweep("inverted", 16'h0500, 16'h0100, 16'h0100, 3, 0, 0);
    run_sweep("dwell0", 16'h0010, 16'h0020, 16'h0010, 0, 2, 0);

    // Async reset mid-sweep: outputs must clear before any clock edge.
    @(posedge clk); #1;
    f_start = 16'h0100; f_stop = 16'h0F00; f_step = 16'h0100; dwell = 4;
    start = 1'b1; tready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_tdata", tdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // start together with abort in IDLE is refused.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_tvalid", tvalid, 0);

    run_sweep("post_rst", 16'h0010, 16'h0020, 16'h0010, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      int unsigned fs = $urandom_range(0, 16'h0FFF);
      int unsigned fe = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16'h0FFF)
                                                    : fs + $urandom_range(0, 16'h0800);
      int unsigned st = $urandom_range(16'h0100, 16'h0400);
      int unsigned dw = $urandom_range(0, 3);
      run_sweep($sformatf("rnd%0d", t), fs, fe, st, dw, 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
